mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter between the core's instruction-fetch path and its load/store path. Both requesters share one memory port carrying a single outstanding transaction. Conflicts are resolved round-robin, and each response is routed back to the requester that issued it. A saturating counter of fetch-stall cycles feeds the core's debug/performance view.

## Interface
Parameters:
- ADDR_W, 32, address width for both requesters and the memory port
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- CNT_W, 16, width of the fetch-stall counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset; the polarity and synchronicity are fixed
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_W  fetch address
- if_rsp_valid  out  1  one-cycle pulse: if_rdata is valid
- if_rdata  out  DATA_W  fetched instruction word
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_addr  in  ADDR_W  load/store address
- ls_we  in  1  1 = store
- ls_be  in  DATA_W/8  byte enables
- ls_wdata  in  DATA_W  store data
- ls_rsp_valid  out  1  one-cycle pulse: load data returned or store acknowledged
- ls_rdata  out  DATA_W  load data; don't-care on a store acknowledge
- mem_req  out  1  memory request, held until granted
- mem_gnt  in  1  memory accepts the request
- mem_addr, mem_we, mem_be, mem_wdata  out  ADDR_W/1/DATA_W/8/DATA_W  latched request fields
- mem_rvalid  in  1  response strobe; asserted for both reads and writes
- mem_rdata  in  DATA_W  read data
- fetch_stall_cnt  out  CNT_W  saturating count of cycles with if_req_valid=1 and if_req_ready=0

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE**
  - If exactly one requester is valid, that requester wins.
  - If both are valid, the port named by prio wins.
  - The winner's ready is asserted combinationally in this cycle.
  - addr/we/be/wdata and the owner ID are latched; the FSM moves to REQ.
  - A fetch is latched as we=0, be=all-ones, wdata=0.
- **REQ**
  - mem_req=1 with the latched fields, held stable until mem_gnt=1.
  - On mem_gnt=1 the FSM moves to RESP.
- **RESP**
  - mem_req=0; the FSM waits for mem_rvalid=1.
  - On mem_rvalid=1, mem_rdata is registered into the owner's rdata, the owner's rsp_valid pulses on the next cycle, and the FSM moves to IDLE.
- **Priority**
  - prio resets to fetch.
  - After every accept, prio points to the port that was not granted.
- **Requester rules**
  - A requester holds valid and its fields stable until ready is seen.
  - The arbiter never drops an accepted request.
- mem_rvalid is ignored in IDLE and REQ; stray responses are discarded.
- **fetch_stall_cnt**
  - Increments every cycle that if_req_valid=1 and if_req_ready=0.
  - Saturates at 2^CNT_W-1; it never wraps.
- The non-owner's rdata holds its previous value.

## Timing
- **Reset values**
  - FSM=IDLE, prio=fetch, mem_req=0.
  - All ready and rsp_valid outputs = 0.
  - All data/addr outputs = 0; fetch_stall_cnt = 0.
- Accept to mem_req: 1 cycle. The request is accepted in cycle t, and mem_req is high from t+1.
- mem_gnt in cycle g moves the FSM to RESP at g+1. mem_rvalid is counted only when it arrives at g+1 or later.
- mem_rvalid in cycle r gives rsp_valid=1 in cycle r+1. The FSM is in IDLE in cycle r+1, so a new accept is possible in r+1.
- Minimum turnaround, with mem_gnt in the first REQ cycle and mem_rvalid at the next cycle: accept to rsp_valid is 3 cycles. Back-to-back accepts are spaced 3 cycles apart.
- A simultaneous accept and stall-count increment in the same cycle is legal, since they concern different requesters.
- **Reset mid-operation**
  - Outputs clear immediately (asynchronous reset).
  - The in-flight transaction is abandoned, with no rsp_valid.
  - A late mem_rvalid after reset is released is ignored because the FSM is in IDLE.

## Structure
- The shared core package holds:
  - the state enum for IDLE/REQ/RESP;
  - owner IDs: PORT_IF=0, PORT_LS=1;
  - the default widths.
- The block is a single module; no sub-module is warranted. The round-robin pick is a two-line expression.

## Test plan
- **Lone fetch:** if_req_valid=1, addr 0x0000_0010; mem_gnt same cycle, mem_rvalid next cycle with 0x0000_0013 -> if_rsp_valid one cycle, if_rdata=0x0000_0013, mem_we=0, mem_be=0xF, accept-to-rsp 3 cycles.
- **Store:** ls we=1, be=0x3, addr 0x100, wdata 0xDEAD_BEEF -> mem fields match exactly; ls_rsp_valid pulses after mem_rvalid; if_rsp_valid stays 0.
- **Conflict:** both requesters valid and held continuously from reset -> grants alternate IF, LS, IF, LS; fetch_stall_cnt increments only on cycles where fetch is waiting.
- **Grant stall:** mem_gnt held low for 5 cycles -> mem_req and all mem fields are stable for those 5 cycles; a stray mem_rvalid during REQ is ignored.
- **Mid-transaction reset:** reset asserted during RESP, then mem_rvalid arrives after reset release -> no rsp_valid on either port; prio=fetch; all outputs at reset values.
- **Counter saturation:** with CNT_W=4, fetch is starved behind 20+ stall cycles -> fetch_stall_cnt stops at 15.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch / load-store memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    typedef enum logic {PORT_IF = 1'b0, PORT_LS = 1'b1} port_e;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port between
// instruction fetch and load/store, with a saturating fetch-stall counter.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [CNT_W-1:0]    fetch_stall_cnt
);

    localparam int unsigned BeW = DATA_W / 8;

    state_e              state_q, state_d;
    port_e               prio_q, prio_d;
    port_e               owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [BeW-1:0]      be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                if_rsp_q, if_rsp_d;
    logic                ls_rsp_q, ls_rsp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                if_win, ls_win, rsp_take;

    assign if_win = if_req_valid & (~ls_req_valid | (prio_q == PORT_IF));
    assign ls_win = ls_req_valid & (~if_req_valid | (prio_q == PORT_LS));

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;
        rsp_take     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Readies are gated by reset so nothing is accepted while held in reset.
                if (rst && if_win) begin
                    if_req_ready = 1'b1;
                    owner_d      = PORT_IF;
                    prio_d       = PORT_LS;
                    addr_d       = if_addr;
                    we_d         = 1'b0;
                    be_d         = '1;
                    wdata_d      = '0;
                    state_d      = StReq;
                end else if (rst && ls_win) begin
                    ls_req_ready = 1'b1;
                    owner_d      = PORT_LS;
                    prio_d       = PORT_IF;
                    addr_d       = ls_addr;
                    we_d         = ls_we;
                    be_d         = ls_be;
                    wdata_d      = ls_wdata;
                    state_d      = StReq;
                end
            end
            StReq: begin
                if (mem_gnt) state_d = StResp;
            end
            StResp: begin
                if (mem_rvalid) begin
                    rsp_take = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        if_rsp_d   = rsp_take && (owner_q == PORT_IF);
        ls_rsp_d   = rsp_take && (owner_q == PORT_LS);
        if_rdata_d = if_rsp_d ? mem_rdata : if_rdata_q;
        ls_rdata_d = ls_rsp_d ? mem_rdata : ls_rdata_q;
        cnt_d      = cnt_q;
        if (if_req_valid && !if_req_ready && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            prio_q     <= PORT_IF;
            owner_q    <= PORT_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            if_rsp_q   <= 1'b0;
            ls_rsp_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            if_rsp_q   <= if_rsp_d;
            ls_rsp_q   <= ls_rsp_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_req         = (state_q == StReq);
    assign mem_addr        = addr_q;
    assign mem_we          = we_q;
    assign mem_be          = be_q;
    assign mem_wdata       = wdata_q;
    assign if_rsp_valid    = if_rsp_q;
    assign if_rdata        = if_rdata_q;
    assign ls_rsp_valid    = ls_rsp_q;
    assign ls_rdata        = ls_rdata_q;
    assign fetch_stall_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: accepts push expected responses, responses pop and compare.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_valid = 1'b0, if_req_ready;
    logic [31:0] if_addr = '0;
    logic        if_rsp_valid;
    logic [31:0] if_rdata;
    logic        ls_req_valid = 1'b0, ls_req_ready;
    logic [31:0] ls_addr = '0;
    logic        ls_we = 1'b0;
    logic [3:0]  ls_be = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_rsp_valid;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_gnt = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  fetch_stall_cnt;

    typedef struct {
        int          port;
        logic [31:0] data;
        bit          chk_data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    bit   mem_auto = 1'b0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_we(ls_we), .ls_be(ls_be), .ls_wdata(ls_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .fetch_stall_cnt(fetch_stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Auto memory: grant on the first REQ cycle, answer with addr^3 the cycle after.
    initial begin
        int mp = 0;
        logic [31:0] a = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_auto) begin
                mp = 0;
            end else begin
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                if (mp == 0 && mem_req) begin
                    mem_gnt = 1'b1;
                    a       = mem_addr;
                    mp      = 1;
                end else if (mp == 1) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = a ^ 32'h3;
                    mp         = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (if_rsp_valid || ls_rsp_valid) begin
                check("rsp_both", {31'd0, if_rsp_valid & ls_rsp_valid}, 0);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_port", {31'd0, ls_rsp_valid}, e.port);
                    if (e.chk_data) check("rsp_data", ls_rsp_valid ? ls_rdata : if_rdata, e.data);
                end
            end
            if (if_req_valid && if_req_ready) exp_q.push_back('{0, if_addr ^ 32'h3, 1'b1});
            if (ls_req_valid && ls_req_ready) exp_q.push_back('{1, ls_addr ^ 32'h3, !ls_we});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_accept(input string tag, output int port);
        port = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (if_req_ready || ls_req_ready) begin
                port    = ls_req_ready ? 1 : 0;
                acc_cyc = cyc;
                return;
            end
        end
        check({tag, "_accept_timeout"}, 1, 0);
    endtask

    task automatic wait_rsp(input string tag, output int at);
        at = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (if_rsp_valid || ls_rsp_valid) begin
                at = cyc;
                return;
            end
        end
        check({tag, "_rsp_timeout"}, 1, 0);
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(negedge clk);
        check({tag, "_drain"}, exp_q.size(), 0);
        tick();
    endtask

    initial begin
        int port, at, prev;
        int exp_cnt[5] = '{0, 2, 5, 7, 10};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_if_ready", if_req_ready, 0);
        check("rst_ls_ready", ls_req_ready, 0);
        check("rst_rsp", {if_rsp_valid, ls_rsp_valid}, 0);
        check("rst_rdata", {if_rdata, ls_rdata}, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_fields", {mem_addr, mem_we, mem_be}, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cnt", fetch_stall_cnt, 0);
        do_reset();
        mem_auto = 1'b1;

        // Lone fetch
        if_req_valid = 1'b1;
        if_addr      = 32'h0000_0010;
        wait_accept("fetch", port);
        check("fetch_port", port, 0);
        prev = acc_cyc;
        tick();
        if_req_valid = 1'b0;
        @(negedge clk);
        check("fetch_mem_req", mem_req, 1);
        check("fetch_mem_addr", mem_addr, 32'h10);
        check("fetch_mem_we_be", {mem_we, mem_be}, 5'h0F);
        check("fetch_mem_wdata", mem_wdata, 0);
        wait_rsp("fetch", at);
        check("fetch_latency", at - prev, 3);
        drain("fetch");

        // Store
        ls_req_valid = 1'b1;
        ls_we        = 1'b1;
        ls_be        = 4'h3;
        ls_addr      = 32'h100;
        ls_wdata     = 32'hDEAD_BEEF;
        wait_accept("store", port);
        check("store_port", port, 1);
        prev = acc_cyc;
        tick();
        ls_req_valid = 1'b0;
        @(negedge clk);
        check("store_mem_addr", mem_addr, 32'h100);
        check("store_mem_we_be", {mem_we, mem_be}, 5'h13);
        check("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        wait_rsp("store", at);
        check("store_latency", at - prev, 3);
        drain("store");

        // Conflict: both held from reset
        if_req_valid = 1'b1;
        if_addr      = 32'h1000;
        ls_req_valid = 1'b1;
        ls_we        = 1'b0;
        ls_be        = 4'hF;
        ls_addr      = 32'h2000;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wait_accept("conflict", port);
            check($sformatf("conflict_port%0d", i), port, i % 2);
            check($sformatf("conflict_cnt%0d", i), fetch_stall_cnt, exp_cnt[i]);
            if (i > 0) check($sformatf("conflict_gap%0d", i), acc_cyc - prev, 3);
            prev = acc_cyc;
            tick();
            if (port == 0) if_addr += 4;
            else ls_addr += 4;
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        drain("conflict");

        // Grant stall, stray rvalid in REQ, counter saturation
        do_reset();
        mem_auto     = 1'b0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        ls_req_valid = 1'b1;
        ls_we        = 1'b1;
        ls_be        = 4'hC;
        ls_addr      = 32'h200;
        ls_wdata     = 32'h1234_5678;
        wait_accept("stall", port);
        check("stall_port", port, 1);
        tick();
        ls_req_valid = 1'b0;
        if_req_valid = 1'b1;
        if_addr      = 32'h40;
        for (int k = 0; k < 25; k++) begin
            mem_rvalid = (k == 2);
            mem_rdata  = (k == 2) ? 32'hBAD0_0000 : 32'h0;
            @(negedge clk);
            if (k < 5) begin
                check("stall_mem_req", mem_req, 1);
                check("stall_mem_fields", {mem_addr, mem_we, mem_be}, {32'h200, 1'b1, 4'hC});
                check("stall_mem_wdata", mem_wdata, 32'h1234_5678);
            end
            if (k == 3) check("stall_stray_rsp", {if_rsp_valid, ls_rsp_valid}, 0);
            if (k == 4) check("stall_if_ready", if_req_ready, 0);
            if (k == 10) check("stall_cnt10", fetch_stall_cnt, 10);
            if (k == 20) check("stall_cnt_sat20", fetch_stall_cnt, 15);
            tick();
        end
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("stall_cnt_sat25", fetch_stall_cnt, 15);
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55;
        tick();
        mem_rvalid = 1'b0;
        mem_auto   = 1'b1;
        wait_accept("stall_if", port);
        check("stall_if_port", port, 0);
        tick();
        if_req_valid = 1'b0;
        drain("stall");

        // Reset during RESP, late rvalid after release
        mem_auto     = 1'b0;
        if_req_valid = 1'b1;
        if_addr      = 32'h80;
        wait_accept("midrst", port);
        tick();
        if_req_valid = 1'b0;
        mem_gnt      = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_rdata", {if_rdata, ls_rdata}, 0);
        check("midrst_mem_fields", {mem_addr, mem_we, mem_be}, 0);
        check("midrst_cnt", fetch_stall_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77;
        tick();
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_no_rsp", {if_rsp_valid, ls_rsp_valid}, 0);
        end
        tick();
        mem_auto     = 1'b1;
        if_req_valid = 1'b1;
        if_addr      = 32'h84;
        ls_req_valid = 1'b1;
        ls_we        = 1'b0;
        ls_addr      = 32'h300;
        wait_accept("midrst_prio", port);
        check("midrst_prio_port", port, 0);
        tick();
        if_req_valid = 1'b0;
        wait_accept("midrst_ls", port);
        check("midrst_ls_port", port, 1);
        tick();
        ls_req_valid = 1'b0;
        drain("midrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
